// File: rtl/arbitro_escritura_registros_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_escritura_registros_pkg
// Brief    : Shared widths, requester indices and pointer encoding for the
//            register-file write-port arbiter.
// Revision : 1.0
// ============================================================================
package arbitro_escritura_registros_pkg;

    localparam int c_ANCHO_DATOS = 32;
    localparam int c_ANCHO_DIR   = 5;

    // Bit positions of each requester inside the grant vector.
    localparam int c_REQ_A = 0;
    localparam int c_REQ_B = 1;

    localparam int c_DIR_CERO = 0;

    typedef enum logic [0:0] {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } puntero_e;

endpackage : arbitro_escritura_registros_pkg
`default_nettype wire

// File: rtl/arbitro_escritura_registros_if.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_escritura_registros_if
// Brief    : Requester, register-file write and scoreboard signals of the
//            write-port arbiter.
// Revision : 1.0
// ============================================================================
interface arbitro_escritura_registros_if
    import arbitro_escritura_registros_pkg::*;
#(
    parameter int ANCHO_DATOS = c_ANCHO_DATOS,
    parameter int ANCHO_DIR   = c_ANCHO_DIR
);

    localparam int NUM_REGS = 2 ** ANCHO_DIR;

    logic                   validoA;
    logic [ANCHO_DIR-1:0]   dirA;
    logic [ANCHO_DATOS-1:0] datoA;
    logic                   listoA;

    logic                   validoB;
    logic [ANCHO_DIR-1:0]   dirB;
    logic [ANCHO_DATOS-1:0] datoB;
    logic                   listoB;

    logic                   WE;
    logic [ANCHO_DIR-1:0]   direccionEscritura;
    logic [ANCHO_DATOS-1:0] datos;

    logic                   reservar;
    logic [ANCHO_DIR-1:0]   dirReserva;
    logic [ANCHO_DIR-1:0]   primerDireccionLectura;
    logic [ANCHO_DIR-1:0]   segundaDireccionLectura;
    logic                   riesgo;
    logic [NUM_REGS-1:0]    ocupados;

    modport master (
        output validoA, dirA, datoA,
        input  listoA,
        output validoB, dirB, datoB,
        input  listoB,
        input  WE, direccionEscritura, datos,
        output reservar, dirReserva,
        output primerDireccionLectura, segundaDireccionLectura,
        input  riesgo, ocupados
    );

    modport slave (
        input  validoA, dirA, datoA,
        output listoA,
        input  validoB, dirB, datoB,
        output listoB,
        output WE, direccionEscritura, datos,
        input  reservar, dirReserva,
        input  primerDireccionLectura, segundaDireccionLectura,
        output riesgo, ocupados
    );

endinterface : arbitro_escritura_registros_if
`default_nettype wire

// File: rtl/arbitro_escritura_registros_marcador_ocupados.sv
`default_nettype none
// ============================================================================
// Module   : marcador_ocupados
// Brief    : Pending-write busy mask with set/clear per register and the
//            read-after-write hazard lookup for two read addresses.
// Revision : 1.0
// ============================================================================
module marcador_ocupados
    import arbitro_escritura_registros_pkg::*;
#(
    parameter int ANCHO_DIR     = c_ANCHO_DIR,
    parameter int PROTEGER_CERO = 1,
    localparam int NUM_REGS     = 2 ** ANCHO_DIR
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_reservar,
    input  wire logic [ANCHO_DIR-1:0] i_dir_reserva,
    input  wire logic                 i_limpiar,
    input  wire logic [ANCHO_DIR-1:0] i_dir_limpiar,
    input  wire logic [ANCHO_DIR-1:0] i_dir_lectura_0,
    input  wire logic [ANCHO_DIR-1:0] i_dir_lectura_1,
    output logic                      o_riesgo,
    output logic [NUM_REGS-1:0]       o_ocupados
);

    logic [NUM_REGS-1:0] r_ocupados;
    logic [NUM_REGS-1:0] w_siguiente;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        if ((i == c_DIR_CERO) && (PROTEGER_CERO != 0)) begin : g_cero
            assign w_siguiente[i] = 1'b0;
        end else begin : g_normal
            logic w_set;
            logic w_clr;
            assign w_set = i_reservar && (i_dir_reserva == ANCHO_DIR'(i));
            assign w_clr = i_limpiar  && (i_dir_limpiar == ANCHO_DIR'(i));
            // A new reservation beats the clear of the write that just retired.
            assign w_siguiente[i] = w_set | (r_ocupados[i] & ~w_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ocupados <= '0;
        end else begin
            r_ocupados <= w_siguiente;
        end
    end

    assign o_riesgo   = r_ocupados[i_dir_lectura_0] | r_ocupados[i_dir_lectura_1];
    assign o_ocupados = r_ocupados;

endmodule : marcador_ocupados
`default_nettype wire

// File: rtl/arbitro_escritura_registros.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_escritura_registros
// Brief    : Round-robin arbiter for the single register-file write port
//            (ALU vs. load writeback) with registered write outputs.
// Revision : 1.0
// ============================================================================
module arbitro_escritura_registros
    import arbitro_escritura_registros_pkg::*;
#(
    parameter int ANCHO_DATOS   = c_ANCHO_DATOS,
    parameter int ANCHO_DIR     = c_ANCHO_DIR,
    parameter int PROTEGER_CERO = 1
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    arbitro_escritura_registros_if.slave   bus
);

    puntero_e               r_puntero;
    puntero_e               w_puntero_sig;
    logic [1:0]             w_concede;
    logic                   w_transfer;
    logic [ANCHO_DIR-1:0]   w_dir_gan;
    logic [ANCHO_DATOS-1:0] w_dato_gan;
    logic                   w_escribe;

    logic                   r_we;
    logic [ANCHO_DIR-1:0]   r_dir;
    logic [ANCHO_DATOS-1:0] r_datos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_puntero <= PTR_A;
        end else begin
            r_puntero <= w_puntero_sig;
        end
    end

    always_comb begin
        w_puntero_sig = r_puntero;
        w_concede     = 2'b00;
        if (!rst) begin
            case ({bus.validoB, bus.validoA})
                2'b01:   w_concede[c_REQ_A] = 1'b1;
                2'b10:   w_concede[c_REQ_B] = 1'b1;
                2'b11: begin
                    if (r_puntero == PTR_A) begin
                        w_concede[c_REQ_A] = 1'b1;
                    end else begin
                        w_concede[c_REQ_B] = 1'b1;
                    end
                end
                default: w_concede = 2'b00;
            endcase
            // The pointer always moves to whoever did not just win.
            if (w_concede[c_REQ_A]) begin
                w_puntero_sig = PTR_B;
            end else if (w_concede[c_REQ_B]) begin
                w_puntero_sig = PTR_A;
            end
        end
    end

    assign bus.listoA = w_concede[c_REQ_A];
    assign bus.listoB = w_concede[c_REQ_B];

    assign w_transfer = |w_concede;
    assign w_dir_gan  = w_concede[c_REQ_B] ? bus.dirB  : bus.dirA;
    assign w_dato_gan = w_concede[c_REQ_B] ? bus.datoB : bus.datoA;

    // Writes to register zero are accepted but silently dropped when protected.
    assign w_escribe  = w_transfer &&
                        !((PROTEGER_CERO != 0) && (w_dir_gan == ANCHO_DIR'(c_DIR_CERO)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_dir   <= '0;
            r_datos <= '0;
        end else begin
            r_we <= w_escribe;
            if (w_escribe) begin
                r_dir   <= w_dir_gan;
                r_datos <= w_dato_gan;
            end
        end
    end

    assign bus.WE                 = r_we;
    assign bus.direccionEscritura = r_dir;
    assign bus.datos              = r_datos;

    marcador_ocupados #(
        .ANCHO_DIR     (ANCHO_DIR),
        .PROTEGER_CERO (PROTEGER_CERO)
    ) u_marcador (
        .clk             (clk),
        .rst             (rst),
        .i_reservar      (bus.reservar),
        .i_dir_reserva   (bus.dirReserva),
        .i_limpiar       (r_we),
        .i_dir_limpiar   (r_dir),
        .i_dir_lectura_0 (bus.primerDireccionLectura),
        .i_dir_lectura_1 (bus.segundaDireccionLectura),
        .o_riesgo        (bus.riesgo),
        .o_ocupados      (bus.ocupados)
    );

endmodule : arbitro_escritura_registros
`default_nettype wire

// File: tb/tb_arbitro_escritura_registros.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_escritura_registros
// Brief    : Directed self-checking bench for the write-port arbiter.
// Revision : 1.0
// ============================================================================
module tb_arbitro_escritura_registros;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    arbitro_escritura_registros_if bus ();

    arbitro_escritura_registros #(
        .ANCHO_DATOS   (32),
        .ANCHO_DIR     (5),
        .PROTEGER_CERO (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        bus.validoA = 1'b1; bus.dirA = 5'd1;
        bus.validoB = 1'b1; bus.dirB = 5'd2;
        tick();
        @(negedge clk);
        total++; if (bus.listoA !== 1'b0) begin bad++; $display("FAIL reset_listoA got=%0b want=0", bus.listoA); end
        total++; if (bus.listoB !== 1'b0) begin bad++; $display("FAIL reset_listoB got=%0b want=0", bus.listoB); end
        total++; if (bus.WE !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", bus.WE); end
        total++; if (bus.direccionEscritura !== 5'd0) begin bad++; $display("FAIL reset_dir got=%0d want=0", bus.direccionEscritura); end
        total++; if (bus.datos !== 32'h0) begin bad++; $display("FAIL reset_datos got=%h want=0", bus.datos); end
        total++; if (bus.ocupados !== 32'h0) begin bad++; $display("FAIL reset_ocupados got=%h want=0", bus.ocupados); end
        bus.validoA = 1'b0; bus.validoB = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_a_solo();
        bus.validoA = 1'b1; bus.dirA = 5'd5; bus.datoA = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (bus.listoA !== 1'b1) begin bad++; $display("FAIL a_solo_listoA got=%0b want=1", bus.listoA); end
        total++; if (bus.listoB !== 1'b0) begin bad++; $display("FAIL a_solo_listoB got=%0b want=0", bus.listoB); end
        tick();
        bus.validoA = 1'b0;
        total++; if (bus.WE !== 1'b1) begin bad++; $display("FAIL a_solo_we got=%0b want=1", bus.WE); end
        total++; if (bus.direccionEscritura !== 5'd5) begin bad++; $display("FAIL a_solo_dir got=%0d want=5", bus.direccionEscritura); end
        total++; if (bus.datos !== 32'hDEADBEEF) begin bad++; $display("FAIL a_solo_datos got=%h want=deadbeef", bus.datos); end
        tick();
        total++; if (bus.WE !== 1'b0) begin bad++; $display("FAIL a_solo_we_off got=%0b want=0", bus.WE); end
        total++; if (bus.datos !== 32'hDEADBEEF) begin bad++; $display("FAIL a_solo_hold got=%h want=deadbeef", bus.datos); end
    endtask

    task automatic test_ambos();
        apply_reset();
        bus.validoA = 1'b1; bus.dirA = 5'd3; bus.datoA = 32'h11;
        bus.validoB = 1'b1; bus.dirB = 5'd4; bus.datoB = 32'h22;
        @(negedge clk);
        total++; if (bus.listoA !== 1'b1 || bus.listoB !== 1'b0) begin bad++; $display("FAIL ambos_g1 got=%0b%0b want=10", bus.listoA, bus.listoB); end
        tick();
        bus.validoA = 1'b0;
        total++; if (bus.WE !== 1'b1 || bus.direccionEscritura !== 5'd3 || bus.datos !== 32'h11) begin
            bad++; $display("FAIL ambos_w1 got=%0b/%0d/%h want=1/3/11", bus.WE, bus.direccionEscritura, bus.datos); end
        @(negedge clk);
        total++; if (bus.listoB !== 1'b1) begin bad++; $display("FAIL ambos_g2 got=%0b want=1", bus.listoB); end
        tick();
        bus.validoB = 1'b0;
        total++; if (bus.WE !== 1'b1 || bus.direccionEscritura !== 5'd4 || bus.datos !== 32'h22) begin
            bad++; $display("FAIL ambos_w2 got=%0b/%0d/%h want=1/4/22", bus.WE, bus.direccionEscritura, bus.datos); end
        tick();
        total++; if (bus.WE !== 1'b0) begin bad++; $display("FAIL ambos_we_off got=%0b want=0", bus.WE); end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        bus.validoA = 1'b1; bus.dirA = 5'd10; bus.datoA = 32'hA0;
        bus.validoB = 1'b1; bus.dirB = 5'd11; bus.datoB = 32'hB0;
        for (int k = 0; k < 6; k++) begin
            exp_a = ((k % 2) == 0);
            @(negedge clk);
            total++; if (bus.listoA !== exp_a || bus.listoB !== !exp_a) begin
                bad++; $display("FAIL rr_grant k=%0d got=%0b%0b want=%0b%0b", k, bus.listoA, bus.listoB, exp_a, !exp_a); end
            tick();
            total++; if (bus.WE !== 1'b1 || bus.direccionEscritura !== (exp_a ? 5'd10 : 5'd11)) begin
                bad++; $display("FAIL rr_write k=%0d got=%0b/%0d want=1/%0d", k, bus.WE, bus.direccionEscritura, exp_a ? 10 : 11); end
        end
        bus.validoA = 1'b0; bus.validoB = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        bus.reservar = 1'b1; bus.dirReserva = 5'd7;
        bus.primerDireccionLectura = 5'd7; bus.segundaDireccionLectura = 5'd0;
        tick();
        bus.reservar = 1'b0;
        total++; if (bus.ocupados !== 32'h0000_0080) begin bad++; $display("FAIL sb_set got=%h want=00000080", bus.ocupados); end
        total++; if (bus.riesgo !== 1'b1) begin bad++; $display("FAIL sb_riesgo1 got=%0b want=1", bus.riesgo); end
        bus.primerDireccionLectura = 5'd2; bus.segundaDireccionLectura = 5'd7;
        #1;
        total++; if (bus.riesgo !== 1'b1) begin bad++; $display("FAIL sb_riesgo2 got=%0b want=1", bus.riesgo); end
        bus.segundaDireccionLectura = 5'd6;
        #1;
        total++; if (bus.riesgo !== 1'b0) begin bad++; $display("FAIL sb_libre got=%0b want=0", bus.riesgo); end
        bus.primerDireccionLectura = 5'd7;
        bus.validoB = 1'b1; bus.dirB = 5'd7; bus.datoB = 32'h77;
        @(negedge clk);
        total++; if (bus.listoB !== 1'b1) begin bad++; $display("FAIL sb_listoB got=%0b want=1", bus.listoB); end
        tick();
        bus.validoB = 1'b0;
        total++; if (bus.WE !== 1'b1 || bus.riesgo !== 1'b1) begin bad++; $display("FAIL sb_we_cycle got=%0b/%0b want=1/1", bus.WE, bus.riesgo); end
        tick();
        total++; if (bus.riesgo !== 1'b0 || bus.ocupados !== 32'h0) begin bad++; $display("FAIL sb_clear got=%0b/%h want=0/0", bus.riesgo, bus.ocupados); end
    endtask

    task automatic test_cero();
        bus.validoA = 1'b1; bus.dirA = 5'd0; bus.datoA = 32'hFFFFFFFF;
        @(negedge clk);
        total++; if (bus.listoA !== 1'b1) begin bad++; $display("FAIL cero_listoA got=%0b want=1", bus.listoA); end
        tick();
        bus.validoA = 1'b0;
        total++; if (bus.WE !== 1'b0) begin bad++; $display("FAIL cero_we got=%0b want=0", bus.WE); end
        bus.reservar = 1'b1; bus.dirReserva = 5'd0;
        tick();
        bus.reservar = 1'b0;
        total++; if (bus.ocupados !== 32'h0) begin bad++; $display("FAIL cero_ocupados got=%h want=0", bus.ocupados); end
    endtask

    task automatic test_colision_reset();
        bus.reservar = 1'b1; bus.dirReserva = 5'd9;
        tick();
        bus.reservar = 1'b0;
        bus.validoA = 1'b1; bus.dirA = 5'd9; bus.datoA = 32'h99;
        tick();
        bus.validoA = 1'b0;
        total++; if (bus.WE !== 1'b1 || bus.direccionEscritura !== 5'd9) begin
            bad++; $display("FAIL col_we got=%0b/%0d want=1/9", bus.WE, bus.direccionEscritura); end
        bus.reservar = 1'b1; bus.dirReserva = 5'd9;
        tick();
        bus.reservar = 1'b0;
        total++; if (bus.ocupados !== 32'h0000_0200) begin bad++; $display("FAIL col_set_wins got=%h want=00000200", bus.ocupados); end
        rst = 1'b1;
        bus.validoA = 1'b1; bus.dirA = 5'd13; bus.datoA = 32'h13;
        bus.validoB = 1'b1; bus.dirB = 5'd14; bus.datoB = 32'h14;
        @(negedge clk);
        total++; if (bus.listoA !== 1'b0 || bus.listoB !== 1'b0) begin bad++; $display("FAIL col_rst_listo got=%0b%0b want=00", bus.listoA, bus.listoB); end
        tick();
        rst = 1'b0;
        total++; if (bus.WE !== 1'b0 || bus.ocupados !== 32'h0) begin bad++; $display("FAIL col_rst_state got=%0b/%h want=0/0", bus.WE, bus.ocupados); end
        @(negedge clk);
        total++; if (bus.listoA !== 1'b1 || bus.listoB !== 1'b0) begin bad++; $display("FAIL col_ptr_a got=%0b%0b want=10", bus.listoA, bus.listoB); end
        tick();
        bus.validoA = 1'b0; bus.validoB = 1'b0;
        total++; if (bus.WE !== 1'b1 || bus.direccionEscritura !== 5'd13) begin
            bad++; $display("FAIL col_post_write got=%0b/%0d want=1/13", bus.WE, bus.direccionEscritura); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.validoA = 1'b0; bus.dirA = '0; bus.datoA = '0;
        bus.validoB = 1'b0; bus.dirB = '0; bus.datoB = '0;
        bus.reservar = 1'b0; bus.dirReserva = '0;
        bus.primerDireccionLectura = '0; bus.segundaDireccionLectura = '0;
        test_reset();
        test_a_solo();
        test_ambos();
        test_round_robin();
        test_scoreboard();
        test_cero();
        test_colision_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arbitro_escritura_registros
`default_nettype wire

// File: doc/arbitro_escritura_registros.md
Name: arbitro_escritura_registros

Overview:
Write-port controller for the 32x32 register file (one write port, two read ports). It arbitrates the single write port between two writeback requesters: A = ALU result, B = memory load. Arbitration is round-robin with a valid/ready handshake, and the winning write drives WE, direccionEscritura and datos as registered outputs. The block also keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards against the two read addresses.

Parameters:
ANCHO_DATOS, 32, data width of the register file
ANCHO_DIR, 5, register address width; NUM_REGS = 2**ANCHO_DIR
PROTEGER_CERO, 1, when 1 register 0 is never written or marked busy

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
validoA  in  1  requester A has a write pending
dirA  in  ANCHO_DIR  destination register of A
datoA  in  ANCHO_DATOS  write data of A
listoA  out  1  A accepted this cycle (combinational)
validoB  in  1  requester B has a write pending
dirB  in  ANCHO_DIR  destination register of B
datoB  in  ANCHO_DATOS  write data of B
listoB  out  1  B accepted this cycle (combinational)
WE  out  1  register-file write enable (registered)
direccionEscritura  out  ANCHO_DIR  register-file write address (registered)
datos  out  ANCHO_DATOS  register-file write data (registered)
reservar  in  1  issue stage marks a destination as pending
dirReserva  in  ANCHO_DIR  register to mark busy
primerDireccionLectura  in  ANCHO_DIR  first read address to check
segundaDireccionLectura  in  ANCHO_DIR  second read address to check
riesgo  out  1  either read address is busy (combinational)
ocupados  out  NUM_REGS  scoreboard busy mask (registered)

Behaviour:
- Reset (rst=1 at a clock edge):
  - WE=0, direccionEscritura=0, datos=0, ocupados=0.
  - Priority pointer is set to A.
  - listoA=listoB=0 while rst is high.
- Arbitration is combinational within a cycle, with at most one grant per cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted; the other sees listo=0 and must hold its valid, dir and dato stable.
  - After any grant to X, the pointer moves to the other requester.
  - Neither valid: no grant and the pointer is unchanged.
- Handshake: a transfer occurs when validoX && listoX at the clock edge. listo never depends on the requester's own dir or dato.
- Latency: a transfer accepted at edge N gives WE=1, direccionEscritura=dirX, datos=datoX for exactly the cycle after edge N. With no transfer, WE=0 on the next cycle; address and data hold their last values.
- Back-to-back transfers give WE=1 on consecutive cycles; sustained throughput is one write per cycle.
- PROTEGER_CERO=1 and dirX=0: the transfer completes (listo=1) but WE stays 0. A reservar with dirReserva=0 is ignored, so ocupados[0] is always 0.
- Scoreboard:
  - Set: reservar=1 at an edge sets ocupados[dirReserva].
  - Clear: ocupados[direccionEscritura] clears at the edge that ends a cycle with WE=1, so a hazard stays visible through the write cycle and drops the cycle after.
  - Set and clear of the same register at the same edge: the set wins (new producer).
  - Reserving an already-busy register keeps it busy; there is no count, one outstanding producer per register.
- riesgo = ocupados[primerDireccionLectura] | ocupados[segundaDireccionLectura]. There is no bypass.
- Reset mid-operation: the in-flight WE cycle is dropped, ocupados is cleared, and requesters must reissue.

Decomposition:
- Shared package holds:
  - ANCHO_DATOS and ANCHO_DIR defaults.
  - Requester index constants REQ_A=0 and REQ_B=1.
  - The register-zero address constant.
- Sub-module marcador_ocupados holds the busy mask, its set/clear logic and the riesgo lookup.
- The arbiter, pointer and output registers stay in the top module.

Test Plan:
1. Reset, then A only: validoA=1, dirA=5, datoA=0xDEADBEEF for one cycle -> listoA=1 that cycle; next cycle WE=1, direccionEscritura=5, datos=0xDEADBEEF; the cycle after, WE=0.
2. Both valid for two cycles: A(dir 3, 0x11), B(dir 4, 0x22), pointer at A -> A granted first, B second; WE high two consecutive cycles, writing 3/0x11 then 4/0x22.
3. Round-robin fairness: both valid continuously for 6 cycles -> grants alternate A,B,A,B,A,B, and neither listo is high two cycles in a row.
4. Scoreboard: reservar dir 7, then primerDireccionLectura=7 -> riesgo=1; B writes dir 7 -> riesgo stays 1 during the WE cycle and is 0 the cycle after, with ocupados[7]=0.
5. Register zero (PROTEGER_CERO=1): A writes dir 0, data 0xFFFFFFFF -> listoA=1, WE stays 0; reservar dir 0 -> ocupados stays 0.
6. Set/clear collision and reset: WE cycle to dir 9 coincides with reservar dir 9 -> ocupados[9]=1 after the edge; then rst=1 for one cycle -> WE=0, ocupados=0, and with both valid the next grant goes to A.
